dual_port_ram_64x8: RTL and testbench
=====================================

Name: dual_port_ram_64x8

Overview:
- 64-word x 8-bit RAM with one write/read port (port 0) and one read-only port (port 1), single clock domain.
- Serves as a small scratch/lookup buffer. A producer writes through port 0 while a consumer reads independently through port 1.
- Both read ports are registered. Asynchronous reset clears the whole array and both outputs.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 6, address width in bits.
- DEPTH, 2**ADDR_W (64), number of words. Derived; not overridden independently.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write enable for port 0. Effective only when port_en_0=1.
- data_in  in  DATA_W  write data for port 0.
- addr_in_0  in  ADDR_W  port 0 address (write and read).
- addr_in_1  in  ADDR_W  port 1 address (read only).
- port_en_0  in  1  port 0 enable.
- port_en_1  in  1  port 1 enable.
- data_out_0  out  DATA_W  port 0 registered read data.
- data_out_1  out  DATA_W  port 1 registered read data.

Behaviour:
- Reset:
  - While rst=1, all DEPTH words are 0, data_out_0=0 and data_out_1=0, independent of clk.
  - Writes and reads are ignored while rst is high.
  - Deassertion takes effect at the next rising clk edge.
- Write:
  - At a rising edge with port_en_0=1 and wr_en=1, mem[addr_in_0] <= data_in.
  - No write occurs when port_en_0=0, regardless of wr_en.
- Port 0 read:
  - At a rising edge with port_en_0=1, data_out_0 <= mem[addr_in_0], using the pre-edge contents (read-first).
  - During a write cycle, data_out_0 therefore shows the old word. The new word is visible one cycle later.
- Port 1 read:
  - At a rising edge with port_en_1=1, data_out_1 <= mem[addr_in_1], using pre-edge contents.
  - Latency is 1 cycle from address to data.
- Disabled port:
  - When port_en_x=0, data_out_x holds its last value; it is neither cleared nor tri-stated.
  - wr_en and data_in are don't-care while port_en_0=0.
- Simultaneous access:
  - Port 0 writes and port 1 reads the same address in the same cycle: data_out_1 gets the old word.
  - A port 1 read of that address on the next cycle returns the new word.
  - Both ports reading the same address is always legal.
- Addressing:
  - The full ADDR_W range is valid and there is no out-of-range case.
  - Address 63 followed by 0 needs no special handling.
  - Never-written locations read 0, because reset clears the array.
- No handshake, no busy signal. A new operation may start on every cycle on both ports.
- wr_en has no effect on port 1.

Decomposition:
- Shared package ram_pkg:
  - localparams DATA_W=8, ADDR_W=6, DEPTH=64.
  - typedefs word_t (logic [DATA_W-1:0]) and addr_t (logic [ADDR_W-1:0]).
- Single module; no sub-module is needed.
- The memory array, write logic and the two read registers all live in one always block group with asynchronous reset.

Test Plan:
- Reset check: assert rst for 2 cycles, then read addresses 0..63 on port 1 with port_en_1=1 -> every data_out_1 = 0x00 one cycle after its address.
- Fill and read back: port_en_0=1, wr_en=1, write data i+1 to address i for i=0..15; then port_en_0=0 and read addresses 0..31 on port 1 -> data_out_1 = 1..16 for addresses 0..15 and 0x00 for 16..31, each with 1-cycle latency.
- Write gated by enable: port_en_0=0, wr_en=1, data_in=0xAA, addr_in_0=5 -> a later port 1 read of address 5 returns its previous value (0x06 after the fill test), not 0xAA.
- Collision:
  - Port 0 writes 0x5C to address 10 while port 1 reads address 10 in the same cycle -> data_out_1 = old value 0x0B.
  - Next-cycle read of address 10 -> 0x5C.
  - data_out_0 in the write cycle also shows 0x0B.
- Hold when disabled: read address 3 on port 1 (data_out_1 = 0x04), then drop port_en_1 and change addr_in_1 to 7 -> data_out_1 stays 0x04.
- Async reset mid-operation: assert rst between clock edges during a write burst -> data_out_0 and data_out_1 go to 0 immediately. After release, reading any previously written address returns 0x00.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared widths and word/address types for the 64x8 dual-port RAM.
package ram_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/dual_port_ram_64x8.sv
// dual_port_ram_64x8: 64x8 RAM, port 0 read/write, port 1 read-only, registered read-first outputs.
module dual_port_ram_64x8
  import ram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  word_t data_in,
  input  addr_t addr_in_0,
  input  addr_t addr_in_1,
  input  logic  port_en_0,
  input  logic  port_en_1,
  output word_t data_out_0,
  output word_t data_out_1
);
  word_t r_mem [DEPTH];
  // Reads sample the array before this edge's write lands, giving read-first on both ports.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mem <= '{default: '0};
      data_out_0 <= '0;
      data_out_1 <= '0;
    end else begin
      if (port_en_0 && wr_en) r_mem[addr_in_0] <= data_in;
      if (port_en_0) data_out_0 <= r_mem[addr_in_0];
      if (port_en_1) data_out_1 <= r_mem[addr_in_1];
    end
endmodule

// File: tb/tb_dual_port_ram_64x8.sv
// tb_dual_port_ram_64x8: scoreboard bench; a behavioural model queues expected outputs per cycle.
module tb_dual_port_ram_64x8;
  import ram_pkg::*;
  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  wr_en = 1'b0;
  logic  port_en_0 = 1'b0;
  logic  port_en_1 = 1'b0;
  word_t data_in = '0;
  addr_t addr_in_0 = '0;
  addr_t addr_in_1 = '0;
  word_t data_out_0, data_out_1;
  int errors = 0;
  int checks = 0;
  word_t m_mem [DEPTH];
  word_t m_out0 = '0;
  word_t m_out1 = '0;
  word_t q0 [$];
  word_t q1 [$];
  word_t e0, e1;

  always #5 clk = ~clk;

  dual_port_ram_64x8 dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
    .addr_in_0(addr_in_0), .addr_in_1(addr_in_1),
    .port_en_0(port_en_0), .port_en_1(port_en_1),
    .data_out_0(data_out_0), .data_out_1(data_out_1)
  );

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_out0 = '0;
    m_out1 = '0;
  endtask

  // Predict this edge's outputs from pre-edge model state, apply the write, then clock.
  task automatic tick();
    m_out0 = port_en_0 ? m_mem[addr_in_0] : m_out0;
    m_out1 = port_en_1 ? m_mem[addr_in_1] : m_out1;
    q0.push_back(m_out0);
    q1.push_back(m_out1);
    if (port_en_0 && wr_en) m_mem[addr_in_0] = data_in;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_out_0 !== 8'h00) begin errors++; $display("FAIL reset_out0 got=%h exp=00", data_out_0); end
    checks++;
    if (data_out_1 !== 8'h00) begin errors++; $display("FAIL reset_out1 got=%h exp=00", data_out_1); end
    rst = 1'b0;
    port_en_1 = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      addr_in_1 = addr_t'(a);
      tick();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (data_out_1 !== 8'h00 || data_out_1 !== e1) begin errors++; $display("FAIL reset_read a=%0d got=%h exp=00", a, data_out_1); end
    end
  endtask

  task automatic test_fill();
    port_en_0 = 1'b1;
    wr_en = 1'b1;
    port_en_1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr_in_0 = addr_t'(i);
      data_in = word_t'(i + 1);
      tick();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (data_out_0 !== e0) begin errors++; $display("FAIL fill_out0 a=%0d got=%h exp=%h", i, data_out_0, e0); end
    end
    port_en_0 = 1'b0;
    wr_en = 1'b0;
    port_en_1 = 1'b1;
    for (int a = 0; a < 32; a++) begin
      addr_in_1 = addr_t'(a);
      tick();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (data_out_1 !== word_t'(a < 16 ? a + 1 : 0) || data_out_1 !== e1)
        begin errors++; $display("FAIL fill_read a=%0d got=%h exp=%h", a, data_out_1, word_t'(a < 16 ? a + 1 : 0)); end
    end
  endtask

  task automatic test_gated_write();
    port_en_0 = 1'b0;
    wr_en = 1'b1;
    data_in = 8'hAA;
    addr_in_0 = 6'd5;
    port_en_1 = 1'b0;
    tick();
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    wr_en = 1'b0;
    port_en_1 = 1'b1;
    addr_in_1 = 6'd5;
    tick();
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (data_out_1 !== 8'h06 || data_out_1 !== e1) begin errors++; $display("FAIL gated_write got=%h exp=06", data_out_1); end
  endtask

  task automatic test_collision();
    port_en_0 = 1'b1;
    wr_en = 1'b1;
    addr_in_0 = 6'd10;
    data_in = 8'h5C;
    port_en_1 = 1'b1;
    addr_in_1 = 6'd10;
    tick();
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (data_out_1 !== 8'h0B || data_out_1 !== e1) begin errors++; $display("FAIL collide_out1 got=%h exp=0b", data_out_1); end
    checks++;
    if (data_out_0 !== 8'h0B || data_out_0 !== e0) begin errors++; $display("FAIL collide_out0 got=%h exp=0b", data_out_0); end
    port_en_0 = 1'b0;
    wr_en = 1'b0;
    tick();
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (data_out_1 !== 8'h5C || data_out_1 !== e1) begin errors++; $display("FAIL collide_next got=%h exp=5c", data_out_1); end
    checks++;
    if (data_out_0 !== 8'h0B) begin errors++; $display("FAIL hold_out0 got=%h exp=0b", data_out_0); end
  endtask

  task automatic test_hold();
    port_en_1 = 1'b1;
    addr_in_1 = 6'd3;
    tick();
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (data_out_1 !== 8'h04 || data_out_1 !== e1) begin errors++; $display("FAIL hold_read got=%h exp=04", data_out_1); end
    port_en_1 = 1'b0;
    addr_in_1 = 6'd7;
    repeat (2) begin
      tick();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (data_out_1 !== 8'h04 || data_out_1 !== e1) begin errors++; $display("FAIL hold_out1 got=%h exp=04", data_out_1); end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      port_en_0 = 1'($urandom_range(0, 3) != 0);
      port_en_1 = 1'($urandom_range(0, 3) != 0);
      wr_en = 1'($urandom_range(0, 1));
      data_in = word_t'($urandom);
      addr_in_0 = (n % 7 == 0) ? 6'd63 : (n % 7 == 1) ? 6'd0 : addr_t'($urandom);
      addr_in_1 = (n % 5 == 0) ? addr_in_0 : addr_t'($urandom);
      tick();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (data_out_0 !== e0) begin errors++; $display("FAIL b2b_out0 n=%0d got=%h exp=%h", n, data_out_0, e0); end
      checks++;
      if (data_out_1 !== e1) begin errors++; $display("FAIL b2b_out1 n=%0d got=%h exp=%h", n, data_out_1, e1); end
    end
  endtask

  task automatic test_async_reset();
    port_en_0 = 1'b1;
    wr_en = 1'b1;
    port_en_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_in_0 = addr_t'(20 + i);
      addr_in_1 = addr_t'(20 + i);
      data_in = word_t'(8'h90 + i);
      tick();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
    end
    tick();
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (data_out_1 !== 8'h93 || data_out_1 !== e1) begin errors++; $display("FAIL burst_read got=%h exp=93", data_out_1); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (data_out_0 !== 8'h00) begin errors++; $display("FAIL async_out0 got=%h exp=00", data_out_0); end
    checks++;
    if (data_out_1 !== 8'h00) begin errors++; $display("FAIL async_out1 got=%h exp=00", data_out_1); end
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    port_en_0 = 1'b0;
    wr_en = 1'b0;
    for (int a = 19; a < 25; a++) begin
      addr_in_1 = addr_t'(a);
      tick();
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (data_out_1 !== 8'h00 || data_out_1 !== e1) begin errors++; $display("FAIL post_reset a=%0d got=%h exp=00", a, data_out_1); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_gated_write();
    test_collision();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
